muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_op  input  4  ALU control code: 1010 MUL, 1011 MULH, 1100 MULHSU, 1101 MULHU, 1110 DIV, 1111 DIVU.
REQ-008 req_a, req_b  input  32 each  SrcA and SrcB operands.
REQ-009 flush  input  1  abort any operation in flight.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer takes the result.
REQ-012 resp_result  output  32  result.
REQ-013 resp_zero  output  1  high when resp_result == 0.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, PREP, CALC, FIX and DONE.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid && req_ready, and op/operands are captured on that edge.
REQ-017 IDLE -> PREP on accept. PREP -> CALC, with operands converted to magnitudes per op signedness and result sign recorded. CALC runs exactly 32 cycles using a 6-bit counter. CALC -> FIX. FIX -> DONE, applying sign and high/low word select.
REQ-018 resp_valid SHALL rise exactly 35 rising edges after the accepting edge, for all supported ops unless REQ-024 applies.
REQ-019 SHALL keep DONE, with resp_result and resp_zero stable, until resp_ready; DONE -> IDLE on the resp_valid && resp_ready edge; no new request is accepted in that same cycle.
REQ-020 Multiply SHALL be radix-2 shift-add into a 64-bit product. MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned semantics.
REQ-021 Divide SHALL be restoring radix-2, quotient truncated toward zero. Divide by zero returns 0xFFFFFFFF for DIV and DIVU. DIV of 0x80000000 by 0xFFFFFFFF returns 0x80000000.
REQ-022 An op code 0000–1001 SHALL be accepted and take PREP -> DONE with result 0 and resp_zero=1, latency 2 edges.
REQ-023 flush SHALL force IDLE on the next edge from any state, including DONE, with no response. flush wins over a simultaneous accept.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_result=0, resp_zero=0, busy=0, internal accumulators=0.
REQ-027 Reset mid-operation SHALL discard the operation; the first request after deassertion SHALL behave as from power-up.

Configuration
REQ-024 With MULDIV_EARLY_OUT_EN defined: divide by zero, DIV overflow, and any multiply with an operand of 0 take PREP -> DONE, with resp_valid 2 edges after accept and the same results as REQ-020/021.
REQ-025 Without MULDIV_EARLY_OUT_EN: these cases take the full 35-edge path; no early-out logic is compiled.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op-code localparams (shared with ALU), the state enum typedef, and CALC_ITERS=32.
REQ-029 Sign pre/post conditioning (magnitude, negate, word select) SHALL be one combinational sub-module, muldiv_sign_fix, instanced in PREP and FIX paths.

Verification
REQ-030 MUL 7 × 0xFFFFFFFD -> resp_result 0xFFFFFFEB, resp_zero 0, resp_valid 35 edges after accept.
REQ-031 MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. DIVU 100 / 7 -> 14. DIV x/0 -> 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Latency is 35 without the macro and 2 with it.
REQ-033 Hold resp_ready=0 for 10 cycles after resp_valid -> result stable, req_ready=0, busy=1; then resp_ready=1 -> IDLE next edge.
REQ-034 flush at CALC cycle 10, then a new request -> no resp_valid for the aborted op; the new op completes with correct value and latency.
REQ-035 rst_n low at CALC cycle 20 -> all outputs at reset values immediately (asynchronously); the next DIVU 9 / 3 -> 3.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: ALU op codes,
// FSM state encoding and iteration count.
package muldiv_pkg;

    localparam int CALC_ITERS = 32;

    // ALU control codes (shared with the ALU decoder)
    localparam logic [3:0] OP_MUL    = 4'b1010;
    localparam logic [3:0] OP_MULH   = 4'b1011;
    localparam logic [3:0] OP_MULHSU = 4'b1100;
    localparam logic [3:0] OP_MULHU  = 4'b1101;
    localparam logic [3:0] OP_DIV    = 4'b1110;
    localparam logic [3:0] OP_DIVU   = 4'b1111;

    // State encodings kept as plain constants for legacy code that decodes them
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_PREP = ST_PREP,
        S_CALC = ST_CALC,
        S_FIX  = ST_FIX,
        S_DONE = ST_DONE
    } state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_valid_op(input logic [3:0] op);
        return op >= OP_MUL;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bus of the sequential multiply/divide unit.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            resp_zero;
    logic            busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, flush, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero, busy
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Sign conditioning for muldiv_seq: operand magnitudes and result sign on the
// way in, two's-complement restore and high/low word select on the way out.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]        i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    input  logic [2*XLEN-1:0] i_raw,
    input  logic              i_neg,
    output logic [XLEN-1:0]   o_mag_a,
    output logic [XLEN-1:0]   o_mag_b,
    output logic              o_neg,
    output logic [XLEN-1:0]   o_result
);
    logic              w_a_neg;
    logic              w_b_neg;
    logic [2*XLEN-1:0] w_fixed;

    // Magnitudes and result sign; divide by zero keeps the all-ones quotient positive
    always_comb begin
        w_a_neg = ((i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV)) && i_a[XLEN-1];
        w_b_neg = ((i_op == OP_MULH) || (i_op == OP_DIV)) && i_b[XLEN-1];
        o_mag_a = w_a_neg ? -i_a : i_a;
        o_mag_b = w_b_neg ? -i_b : i_b;
        o_neg   = (w_a_neg ^ w_b_neg) && !(is_div_op(i_op) && (i_b == '0));
    end

    // Low word of a 64-bit negate equals the 32-bit negate, so one path serves quotient and product
    always_comb begin
        w_fixed  = i_neg ? -i_raw : i_raw;
        o_result = ((i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_MULHU))
                   ? w_fixed[2*XLEN-1:XLEN] : w_fixed[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro MULDIV_EARLY_OUT_EN: divide by zero, DIV overflow and multiply
// by zero finish straight from PREP instead of running the full CALC loop.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    state_e            r_state;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg;
    logic [5:0]        r_cnt;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;

    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg;
    logic [XLEN-1:0]   w_fix_result;
    logic              w_is_div;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_raw    (r_acc),
        .i_neg    (r_neg),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_neg    (w_neg),
        .o_result (w_fix_result)
    );

    // One iteration step: r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        w_is_div    = is_div_op(r_op);
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
        w_div_shift = r_acc[2*XLEN-1:XLEN-1];
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        if (!w_div_diff[XLEN]) begin
            w_div_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_div_next = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end
    end

    // Sequencer FSM and datapath registers; flush overrides everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_cnt <= '0;
                    if (!is_valid_op(r_op)) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_state  <= S_DONE;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (w_is_div && (r_b == '0)) begin
                        r_result <= '1;
                        r_zero   <= 1'b0;
                        r_state  <= S_DONE;
                    end else if ((r_op == OP_DIV) && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1)) begin
                        r_result <= {1'b1, {(XLEN-1){1'b0}}};
                        r_zero   <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (!w_is_div && ((r_a == '0) || (r_b == '0))) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_state  <= S_DONE;
`endif
                    end else begin
                        r_opb   <= w_mag_b;
                        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                        r_neg   <= w_neg;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(CALC_ITERS - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_zero   <= (w_fix_result == '0);
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        bus.req_ready   = (r_state == S_IDLE);
        bus.resp_valid  = (r_state == S_DONE);
        bus.busy        = (r_state != S_IDLE);
        bus.resp_result = r_result;
        bus.resp_zero   = r_zero;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, reference-model random
// ops, and hand sequences for back-pressure, flush and mid-operation reset.
module tb_muldiv_seq;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LE = 2;
`else
    localparam int LE = 35;
`endif
    localparam int LF = 35;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t scb[$];
    vec_t vecs[14];

    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(32)) bus();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] sp;
        p = '0;
        case (op)
            OP_MUL:   begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            OP_MULHU: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OP_MULH: begin
                sa = {{32{a[31]}}, a}; sbv = {{32{b[31]}}, b}; sp = sa * sbv; p = sp; return p[63:32];
            end
            OP_MULHSU: begin
                sa = {{32{a[31]}}, a}; sbv = {32'b0, b}; sp = sa * sbv; p = sp; return p[63:32];
            end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sa = {{32{a[31]}}, a}; sbv = {{32{b[31]}}, b}; sp = sa / sbv; p = sp; return p[31:0];
            end
            OP_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < OP_MUL) return 2;
        if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) return LE;
        if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LE;
        if (op != OP_DIV && op != OP_DIVU && (a == 32'd0 || b == 32'd0)) return LE;
        return LF;
    endfunction

    // Drive one request at the falling edge; returns after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        chk("req_ready_before_send", {63'b0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        if (push) begin
            e.res = exp;
            e.lat = lat;
            scb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Count edges from the accepting edge (inclusive) until resp_valid
    task automatic wait_resp(output int n);
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.resp_valid !== 1'b1) chk("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold);
        int   n;
        exp_t e;
        send(op, a, b, exp, lat, 1'b1);
        wait_resp(n);
        if (scb.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = scb.pop_front();
            chk("resp_result", {32'b0, bus.resp_result}, {32'b0, e.res});
            chk("resp_zero", {63'b0, bus.resp_zero}, {63'b0, (e.res == 32'd0)});
            chk("latency", 64'(n), 64'(e.lat));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", {32'b0, bus.resp_result}, {32'b0, exp});
            chk("hold_valid", {63'b0, bus.resp_valid}, 64'd1);
            chk("hold_req_ready", {63'b0, bus.req_ready}, 64'd0);
            chk("hold_busy", {63'b0, bus.busy}, 64'd1);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("idle_req_ready", {63'b0, bus.req_ready}, 64'd1);
        chk("idle_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        chk("idle_busy", {63'b0, bus.busy}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {63'b0, bus.req_ready}, 64'd1);
        chk({tag, "_resp_valid"}, {63'b0, bus.resp_valid}, 64'd0);
        chk({tag, "_resp_result"}, {32'b0, bus.resp_result}, 64'd0);
        chk({tag, "_resp_zero"}, {63'b0, bus.resp_zero}, 64'd0);
        chk({tag, "_busy"}, {63'b0, bus.busy}, 64'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;

        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LF};
        vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LF};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LF};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LF};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LF};
        vecs[5]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        LF};
        vecs[6]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, LE};
        vecs[7]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, LE};
        vecs[8]  = '{OP_DIVU,   32'd7,          32'd0,         32'hFFFF_FFFF, LE};
        vecs[9]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LE};
        vecs[10] = '{OP_MUL,    32'd0,          32'd5,         32'd0,         LE};
        vecs[11] = '{4'b0011,   32'd9,          32'd9,         32'd0,         2};
        vecs[12] = '{OP_MULH,   32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, LF};
        vecs[13] = '{OP_DIV,    32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        LF};

        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
        end

        // Back-pressure: response held for 10 cycles
        run(OP_DIVU, 32'd100, 32'd7, 32'd14, LF, 10);

        // Flush during CALC, then a fresh request
        send(OP_MUL, 32'd3, 32'd4, 32'd12, LF, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", {63'b0, bus.busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid === 1'b1) seen = 1'b1;
        end
        chk("flush_no_resp", {63'b0, seen}, 64'd0);
        run(OP_MUL, 32'd6, 32'd7, 32'd42, LF, 0);

        // Flush beats a simultaneous accept
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MUL;
        bus.req_a     = 32'd2;
        bus.req_b     = 32'd2;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        chk("flush_vs_accept_busy", {63'b0, bus.busy}, 64'd0);

        // Flush while in DONE drops the response
        send(OP_DIVU, 32'd50, 32'd5, 32'd10, LF, 1'b0);
        wait_resp(n);
        chk("done_flush_result", {32'b0, bus.resp_result}, 64'd10);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("done_flush_valid", {63'b0, bus.resp_valid}, 64'd0);
        chk("done_flush_ready", {63'b0, bus.req_ready}, 64'd1);

        // Random ops against the reference model
        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(10, 15));
            ra  = $urandom;
            rb  = (i % 4 == 3) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
            run(rop, ra, rb, ref_result(rop, ra, rb), ref_lat(rop, ra, rb), 0);
        end

        // Asynchronous reset in the middle of CALC
        send(OP_MUL, 32'h1234, 32'h10, 32'h12340, LF, 1'b0);
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        scb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_DIVU, 32'd9, 32'd3, 32'd3, LF, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
